// File: rtl/lv_owt_tx_arb_pkg.sv
// Shared types for the LV->HV one-wire transaction arbiter: FSM state
// encodings, OWT command codes and the fixed-priority requester pick.
package lv_owt_tx_arb_pkg;

  localparam int ARB_FSM_ST_W = 3;
  localparam int OWT_CMD_W    = 2;

  typedef enum logic [ARB_FSM_ST_W-1:0] {
    ARB_IDLE  = 3'd0,
    ARB_ISSUE = 3'd1,
    ARB_WAIT  = 3'd2,
    ARB_RETRY = 3'd3,
    ARB_ERR   = 3'd4,
    ARB_DONE  = 3'd5
  } arb_st_e;

  typedef enum logic [OWT_CMD_W-1:0] {
    OWT_CMD_WDG  = 2'b00,
    OWT_CMD_WR   = 2'b01,
    OWT_CMD_RD   = 2'b10,
    OWT_CMD_SCAN = 2'b11
  } owt_cmd_e;

  typedef struct packed {
    logic wdg;
    logic wr;
    logic rd;
    logic scan;
  } arb_req_t;

  function automatic logic arb_any(input arb_req_t req);
    return req.wdg | req.wr | req.rd | req.scan;
  endfunction

  // Highest-priority pending requester; only meaningful when arb_any() is true.
  function automatic owt_cmd_e arb_pick(input arb_req_t req);
    owt_cmd_e win;
    if (req.wdg) begin
      win = OWT_CMD_WDG;
    end else if (req.wr) begin
      win = OWT_CMD_WR;
    end else if (req.rd) begin
      win = OWT_CMD_RD;
    end else begin
      win = OWT_CMD_SCAN;
    end
    return win;
  endfunction

endpackage

// File: rtl/lv_owt_tx_arb_if.sv
// Handshake bundle between the arbiter and the OWT tx/rx engine pair.
interface lv_owt_tx_arb_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
);
  import lv_owt_tx_arb_pkg::*;

  logic                 tx_vld;
  logic                 tx_rdy;
  logic [OWT_CMD_W-1:0] tx_cmd;
  logic [ADDR_W-1:0]    tx_addr;
  logic [DATA_W-1:0]    tx_data;
  logic                 rx_vld;
  logic                 rx_ok;
  logic [DATA_W-1:0]    rx_data;

  modport master (
    output tx_vld, tx_cmd, tx_addr, tx_data,
    input  tx_rdy, rx_vld, rx_ok, rx_data
  );

  modport slave (
    input  tx_vld, tx_cmd, tx_addr, tx_data,
    output tx_rdy, rx_vld, rx_ok, rx_data
  );

endinterface

// File: rtl/lv_owt_scan_timer.sv
// Periodic HV status scan timer: raises scan_pend every SCAN_PRD_CYC cycles
// and flags a miss when a period elapses while the previous scan is still pending.
module lv_owt_scan_timer
  import lv_owt_tx_arb_pkg::*;
#(
  parameter int SCAN_PRD_CYC = 4095,
  parameter int SCAN_CNT_W   = 12
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic en,
  input  logic clr_pend,
  output logic o_scan_pend,
  output logic o_scan_miss
);

  logic [SCAN_CNT_W-1:0] cnt_q, cnt_d;
  logic                  pend_q, pend_d;
  logic                  miss_q, miss_d;

  // A wrap sets pend even when the grant is being cleared the same cycle: a new period has elapsed.
  always_comb begin
    cnt_d  = cnt_q;
    pend_d = pend_q;
    miss_d = 1'b0;
    if (!en) begin
      cnt_d  = '0;
      pend_d = 1'b0;
    end else if (cnt_q == SCAN_CNT_W'(SCAN_PRD_CYC - 1)) begin
      cnt_d  = '0;
      pend_d = 1'b1;
      miss_d = pend_q & ~clr_pend;
    end else begin
      cnt_d = cnt_q + SCAN_CNT_W'(1);
      if (clr_pend) begin
        pend_d = 1'b0;
      end else begin
        pend_d = pend_q;
      end
    end
  end

  // Timer state registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q  <= '0;
      pend_q <= 1'b0;
      miss_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
      miss_q <= miss_d;
    end
  end

  assign o_scan_pend = pend_q;
  assign o_scan_miss = miss_q;

endmodule

// File: rtl/lv_owt_tx_arb.sv
// Arbitrates WDG / SPI write / SPI read / periodic scan requests onto the single
// OWT tx/rx engine pair, with response timeout, CRC-fail retry and com-error reporting.
module lv_owt_tx_arb
  import lv_owt_tx_arb_pkg::*;
#(
  parameter int                    OWT_ADDR_W   = 7,
  parameter int                    OWT_DATA_W   = 8,
  parameter int                    ACK_TMO_CYC  = 1023,
  parameter int                    TMO_CNT_W    = 10,
  parameter int                    RETRY_MAX    = 2,
  parameter int                    SCAN_PRD_CYC = 4095,
  parameter int                    SCAN_CNT_W   = 12,
  parameter logic [OWT_ADDR_W-1:0] SCAN_ADDR    = 7'h10
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_owt_com_en,
  input  logic                    i_wdg_scan_en,
  input  logic                    i_fsm_wdg_owt_tx_req,
  output logic                    o_fsm_owt_rx_ack,
  input  logic                    i_spi_wr_req,
  input  logic [OWT_ADDR_W-1:0]   i_spi_wr_addr,
  input  logic [OWT_DATA_W-1:0]   i_spi_wr_data,
  output logic                    o_spi_wr_ack,
  input  logic                    i_spi_rd_req,
  input  logic [OWT_ADDR_W-1:0]   i_spi_rd_addr,
  output logic                    o_spi_rd_ack,
  output logic                    o_rsp_err,
  output logic [OWT_DATA_W-1:0]   o_rsp_data,
  output logic                    o_scan_data_vld,
  output logic                    o_scan_miss,
  lv_owt_tx_arb_if.master         owt,
  output logic                    o_owt_com_err,
  output logic [ARB_FSM_ST_W-1:0] o_arb_cur_st
);

  // Sized so the counter can hold RETRY_MAX even when RETRY_MAX is 0.
  localparam int RTY_W = $clog2(RETRY_MAX + 2);

  arb_st_e               state_q, state_d;
  owt_cmd_e              cmd_q, cmd_d;
  logic [OWT_ADDR_W-1:0] addr_q, addr_d;
  logic [OWT_DATA_W-1:0] data_q, data_d;
  logic [TMO_CNT_W-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic [RTY_W-1:0]      retry_cnt_q, retry_cnt_d;
  logic                  fail_q, fail_d;
  logic                  tx_vld_q, tx_vld_d;
  logic                  fsm_ack_q, fsm_ack_d;
  logic                  wr_ack_q, wr_ack_d;
  logic                  rd_ack_q, rd_ack_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [OWT_DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic                  scan_vld_q, scan_vld_d;
  logic                  com_err_q, com_err_d;

  arb_req_t              req_s;
  owt_cmd_e              win_s;
  logic                  ack_go_s;
  logic                  scan_clr_s;
  logic                  scan_pend_s;

  lv_owt_scan_timer #(
    .SCAN_PRD_CYC (SCAN_PRD_CYC),
    .SCAN_CNT_W   (SCAN_CNT_W)
  ) u_scan_timer (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .en          (i_wdg_scan_en & i_owt_com_en),
    .clr_pend    (scan_clr_s),
    .o_scan_pend (scan_pend_s),
    .o_scan_miss (o_scan_miss)
  );

  assign req_s = {i_fsm_wdg_owt_tx_req, i_spi_wr_req, i_spi_rd_req, scan_pend_s};
  assign win_s = arb_pick(req_s);

  // Next-state and registered-output logic; acks are raised on the cycle that enters ARB_DONE.
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    addr_d      = addr_q;
    data_d      = data_q;
    tmo_cnt_d   = tmo_cnt_q;
    retry_cnt_d = retry_cnt_q;
    fail_d      = fail_q;
    rsp_data_d  = rsp_data_q;
    tx_vld_d    = 1'b0;
    fsm_ack_d   = 1'b0;
    wr_ack_d    = 1'b0;
    rd_ack_d    = 1'b0;
    rsp_err_d   = 1'b0;
    scan_vld_d  = 1'b0;
    com_err_d   = 1'b0;
    ack_go_s    = 1'b0;
    scan_clr_s  = 1'b0;

    if (!i_owt_com_en) begin
      state_d     = ARB_IDLE;
      tmo_cnt_d   = '0;
      retry_cnt_d = '0;
      fail_d      = 1'b0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (arb_any(req_s)) begin
            state_d  = ARB_ISSUE;
            tx_vld_d = 1'b1;
            cmd_d    = win_s;
            case (win_s)
              OWT_CMD_WR: begin
                addr_d = i_spi_wr_addr;
                data_d = i_spi_wr_data;
              end
              OWT_CMD_RD: begin
                addr_d = i_spi_rd_addr;
                data_d = '0;
              end
              OWT_CMD_SCAN: begin
                addr_d = SCAN_ADDR;
                data_d = '0;
              end
              default: begin
                addr_d = '0;
                data_d = '0;
              end
            endcase
          end else begin
            state_d = ARB_IDLE;
          end
        end
        ARB_ISSUE: begin
          if (owt.tx_rdy) begin
            state_d   = ARB_WAIT;
            tmo_cnt_d = '0;
          end else begin
            tx_vld_d = 1'b1;
          end
        end
        ARB_WAIT: begin
          tmo_cnt_d = tmo_cnt_q + TMO_CNT_W'(1);
          // A good response in the timeout cycle still completes the transaction.
          if (owt.rx_vld && owt.rx_ok) begin
            state_d    = ARB_DONE;
            ack_go_s   = 1'b1;
            rsp_err_d  = fail_q;
            scan_vld_d = (cmd_q == OWT_CMD_SCAN);
            if ((cmd_q == OWT_CMD_RD) || (cmd_q == OWT_CMD_SCAN)) begin
              rsp_data_d = owt.rx_data;
            end else begin
              rsp_data_d = rsp_data_q;
            end
          end else if (owt.rx_vld || (tmo_cnt_q == TMO_CNT_W'(ACK_TMO_CYC - 1))) begin
            state_d = ARB_RETRY;
          end else begin
            state_d = ARB_WAIT;
          end
        end
        ARB_RETRY: begin
          if (retry_cnt_q == RTY_W'(RETRY_MAX)) begin
            state_d   = ARB_ERR;
            com_err_d = 1'b1;
            fail_d    = 1'b1;
          end else begin
            state_d     = ARB_ISSUE;
            retry_cnt_d = retry_cnt_q + RTY_W'(1);
            tx_vld_d    = 1'b1;
          end
        end
        ARB_ERR: begin
          state_d   = ARB_DONE;
          ack_go_s  = 1'b1;
          rsp_err_d = fail_q;
        end
        ARB_DONE: begin
          state_d     = ARB_IDLE;
          scan_clr_s  = (cmd_q == OWT_CMD_SCAN);
          retry_cnt_d = '0;
          fail_d      = 1'b0;
        end
        default: begin
          state_d = ARB_IDLE;
        end
      endcase
    end

    if (ack_go_s) begin
      case (cmd_q)
        OWT_CMD_WDG: fsm_ack_d = 1'b1;
        OWT_CMD_WR:  wr_ack_d  = 1'b1;
        OWT_CMD_RD:  rd_ack_d  = 1'b1;
        default:     fsm_ack_d = 1'b0;
      endcase
    end
  end

  // Arbiter state and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ARB_IDLE;
      cmd_q       <= OWT_CMD_WDG;
      addr_q      <= '0;
      data_q      <= '0;
      tmo_cnt_q   <= '0;
      retry_cnt_q <= '0;
      fail_q      <= 1'b0;
      tx_vld_q    <= 1'b0;
      fsm_ack_q   <= 1'b0;
      wr_ack_q    <= 1'b0;
      rd_ack_q    <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
      scan_vld_q  <= 1'b0;
      com_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      tmo_cnt_q   <= tmo_cnt_d;
      retry_cnt_q <= retry_cnt_d;
      fail_q      <= fail_d;
      tx_vld_q    <= tx_vld_d;
      fsm_ack_q   <= fsm_ack_d;
      wr_ack_q    <= wr_ack_d;
      rd_ack_q    <= rd_ack_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
      scan_vld_q  <= scan_vld_d;
      com_err_q   <= com_err_d;
    end
  end

  assign owt.tx_vld       = tx_vld_q;
  assign owt.tx_cmd       = cmd_q;
  assign owt.tx_addr      = addr_q;
  assign owt.tx_data      = data_q;
  assign o_fsm_owt_rx_ack = fsm_ack_q;
  assign o_spi_wr_ack     = wr_ack_q;
  assign o_spi_rd_ack     = rd_ack_q;
  assign o_rsp_err        = rsp_err_q;
  assign o_rsp_data       = rsp_data_q;
  assign o_scan_data_vld  = scan_vld_q;
  assign o_owt_com_err    = com_err_q;
  assign o_arb_cur_st     = state_q;

endmodule

// File: tb/tb_lv_owt_tx_arb.sv
// Scoreboard bench for lv_owt_tx_arb: stimulus queues expected tx handshakes,
// acks, com-errors and scan misses (with their cycle); a negedge monitor pops and compares.
module tb_lv_owt_tx_arb;
  import lv_owt_tx_arb_pkg::*;

  localparam int AW = 7;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          com_en, scan_en, fsm_req, wr_req, rd_req;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [DW-1:0] wr_data;
  logic          fsm_ack, wr_ack, rd_ack, rsp_err, scan_vld, scan_miss, com_err;
  logic [DW-1:0] rsp_data;
  logic [ARB_FSM_ST_W-1:0] cur_st;

  lv_owt_tx_arb_if #(.ADDR_W(AW), .DATA_W(DW)) owt ();

  lv_owt_tx_arb #(
    .OWT_ADDR_W(AW), .OWT_DATA_W(DW), .ACK_TMO_CYC(8), .TMO_CNT_W(10),
    .RETRY_MAX(2), .SCAN_PRD_CYC(64), .SCAN_CNT_W(12), .SCAN_ADDR(7'h10)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_owt_com_en(com_en), .i_wdg_scan_en(scan_en),
    .i_fsm_wdg_owt_tx_req(fsm_req), .o_fsm_owt_rx_ack(fsm_ack),
    .i_spi_wr_req(wr_req), .i_spi_wr_addr(wr_addr), .i_spi_wr_data(wr_data), .o_spi_wr_ack(wr_ack),
    .i_spi_rd_req(rd_req), .i_spi_rd_addr(rd_addr), .o_spi_rd_ack(rd_ack),
    .o_rsp_err(rsp_err), .o_rsp_data(rsp_data), .o_scan_data_vld(scan_vld), .o_scan_miss(scan_miss),
    .owt(owt.master), .o_owt_com_err(com_err), .o_arb_cur_st(cur_st)
  );

  typedef struct { logic [1:0] cmd; logic [AW-1:0] addr; logic [DW-1:0] data; int cyc; } tx_exp_t;
  typedef struct { logic [3:0] who; logic err; logic [DW-1:0] data; int cyc; } ack_exp_t;

  // who one-hot: {fsm_ack, wr_ack, rd_ack, scan_data_vld}
  localparam logic [3:0] W_WDG = 4'b1000;
  localparam logic [3:0] W_WR  = 4'b0100;
  localparam logic [3:0] W_RD  = 4'b0010;
  localparam logic [3:0] W_SC  = 4'b0001;

  tx_exp_t  q_tx[$];
  ack_exp_t q_ack[$];
  int       q_cerr[$];
  int       q_miss[$];

  int n_checks = 0;
  int n_err = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    n_checks++;
    n_err++;
    $display("FAIL %s: got event at cycle %0d expected none", name, cyc);
  endtask

  // Monitor: every DUT-presented event is matched against the head of its queue.
  tx_exp_t  m_tx;
  ack_exp_t m_ack;
  int       m_c;
  always @(negedge clk) begin
    if (rst_n) begin
      if (owt.tx_vld && owt.tx_rdy) begin
        if (q_tx.size() == 0) unexpected("tx_hs");
        else begin
          m_tx = q_tx.pop_front();
          chk("tx_cmd", 32'(owt.tx_cmd), 32'(m_tx.cmd));
          chk("tx_addr", 32'(owt.tx_addr), 32'(m_tx.addr));
          chk("tx_data", 32'(owt.tx_data), 32'(m_tx.data));
          chk("tx_cycle", cyc, m_tx.cyc);
        end
      end
      if (fsm_ack || wr_ack || rd_ack || scan_vld) begin
        if (q_ack.size() == 0) unexpected("ack");
        else begin
          m_ack = q_ack.pop_front();
          chk("ack_who", 32'({fsm_ack, wr_ack, rd_ack, scan_vld}), 32'(m_ack.who));
          chk("ack_rsp_err", 32'(rsp_err), 32'(m_ack.err));
          chk("ack_rsp_data", 32'(rsp_data), 32'(m_ack.data));
          chk("ack_cycle", cyc, m_ack.cyc);
        end
      end
      if (com_err) begin
        if (q_cerr.size() == 0) unexpected("com_err");
        else begin
          m_c = q_cerr.pop_front();
          chk("com_err_cycle", cyc, m_c);
        end
      end
      if (scan_miss) begin
        if (q_miss.size() == 0) unexpected("scan_miss");
        else begin
          m_c = q_miss.pop_front();
          chk("scan_miss_cycle", cyc, m_c);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rx_drive(input logic ok, input logic [DW-1:0] d);
    owt.rx_vld = 1'b1; owt.rx_ok = ok; owt.rx_data = d;
  endtask

  task automatic rx_off();
    owt.rx_vld = 1'b0; owt.rx_ok = 1'b0; owt.rx_data = 8'h00;
  endtask

  task automatic drop(input logic [3:0] who);
    if (who[3]) fsm_req = 1'b0;
    if (who[2]) wr_req = 1'b0;
    if (who[1]) rd_req = 1'b0;
  endtask

  // DUT in ARB_IDLE with requests visible in this cycle; tx_rdy=1, good response after k wait cycles.
  task automatic serve_ok(input logic [1:0] cmd, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                          input logic [3:0] who, input logic [DW-1:0] rxd, input logic [DW-1:0] exp_rsp,
                          input int k);
    chk("grant_from_idle", 32'(cur_st), 32'(ARB_IDLE));
    q_tx.push_back('{cmd: cmd, addr: addr, data: data, cyc: cyc + 1});
    tick(1);
    chk("tx_vld_after_grant", 32'(owt.tx_vld), 32'd1);
    tick(1 + k);
    rx_drive(1'b1, rxd);
    q_ack.push_back('{who: who, err: 1'b0, data: exp_rsp, cyc: cyc + 1});
    tick(1);
    rx_off();
    drop(who);
    tick(1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  int c;
  initial begin
    com_en = 1'b1; scan_en = 1'b0; fsm_req = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
    wr_addr = 7'h00; wr_data = 8'h00; rd_addr = 7'h00;
    owt.tx_rdy = 1'b1; rx_off();
    tick(3);
    chk("rst_state", 32'(cur_st), 32'(ARB_IDLE));
    chk("rst_tx_vld", 32'(owt.tx_vld), 32'd0);
    chk("rst_tx_cmd", 32'(owt.tx_cmd), 32'd0);
    chk("rst_tx_addr", 32'(owt.tx_addr), 32'd0);
    chk("rst_tx_data", 32'(owt.tx_data), 32'd0);
    chk("rst_acks", 32'({fsm_ack, wr_ack, rd_ack, scan_vld}), 32'd0);
    chk("rst_rsp", 32'({rsp_err, rsp_data}), 32'd0);
    chk("rst_err_miss", 32'({com_err, scan_miss}), 32'd0);
    rst_n = 1'b1;
    tick(2);

    // Simultaneous WDG/WR/RD: priority order; RD response in the timeout cycle still wins.
    fsm_req = 1'b1;
    wr_req = 1'b1; wr_addr = 7'h05; wr_data = 8'hA5;
    rd_req = 1'b1; rd_addr = 7'h22;
    serve_ok(OWT_CMD_WDG, 7'h00, 8'h00, W_WDG, 8'h77, 8'h00, 0);
    serve_ok(OWT_CMD_WR,  7'h05, 8'hA5, W_WR,  8'h99, 8'h00, 3);
    serve_ok(OWT_CMD_RD,  7'h22, 8'h00, W_RD,  8'h3C, 8'h3C, 7);
    tick(2);

    // WR with no response: 3 attempts (ACK_TMO_CYC wait cycles + retry cycle apart), com_err, failed ack.
    wr_addr = 7'h33; wr_data = 8'h5A; wr_req = 1'b1;
    c = cyc;
    q_tx.push_back('{cmd: OWT_CMD_WR, addr: 7'h33, data: 8'h5A, cyc: c + 1});
    q_tx.push_back('{cmd: OWT_CMD_WR, addr: 7'h33, data: 8'h5A, cyc: c + 11});
    q_tx.push_back('{cmd: OWT_CMD_WR, addr: 7'h33, data: 8'h5A, cyc: c + 21});
    q_cerr.push_back(c + 31);
    q_ack.push_back('{who: W_WR, err: 1'b1, data: 8'h3C, cyc: c + 32});
    tick(1);
    wr_addr = 7'h7F; wr_data = 8'hFF;
    tick(9);
    chk("retry_state", 32'(cur_st), 32'(ARB_RETRY));
    rx_drive(1'b1, 8'h11);
    tick(1);
    rx_off();
    tick(21);
    drop(W_WR);
    tick(1);
    chk("idle_after_fail", 32'(cur_st), 32'(ARB_IDLE));
    tick(2);

    // RD: first response CRC-bad, second good -> exactly two handshakes, no com_err.
    rd_addr = 7'h41; rd_req = 1'b1;
    c = cyc;
    q_tx.push_back('{cmd: OWT_CMD_RD, addr: 7'h41, data: 8'h00, cyc: c + 1});
    q_tx.push_back('{cmd: OWT_CMD_RD, addr: 7'h41, data: 8'h00, cyc: c + 4});
    q_ack.push_back('{who: W_RD, err: 1'b0, data: 8'h5C, cyc: c + 7});
    tick(2);
    rx_drive(1'b0, 8'hEE);
    tick(1);
    rx_off();
    tick(3);
    rx_drive(1'b1, 8'h5C);
    tick(1);
    rx_off();
    drop(W_RD);
    tick(3);

    // Scan: engine stalled, second wrap reports a miss; scan later completes to SCAN_ADDR.
    owt.tx_rdy = 1'b0; scan_en = 1'b1;
    c = cyc;
    q_miss.push_back(c + 128);
    tick(64);
    chk("scan_not_yet", 32'(cur_st), 32'(ARB_IDLE));
    tick(1);
    chk("scan_issue", 32'(cur_st), 32'(ARB_ISSUE));
    chk("scan_tx_vld", 32'(owt.tx_vld), 32'd1);
    tick(65);
    owt.tx_rdy = 1'b1;
    q_tx.push_back('{cmd: OWT_CMD_SCAN, addr: 7'h10, data: 8'h00, cyc: c + 130});
    tick(1);
    rx_drive(1'b1, 8'hC3);
    q_ack.push_back('{who: W_SC, err: 1'b0, data: 8'hC3, cyc: c + 132});
    tick(1);
    rx_off();
    tick(1);
    chk("scan_done_idle", 32'(cur_st), 32'(ARB_IDLE));
    tick(1);
    chk("scan_no_regrant", 32'(cur_st), 32'(ARB_IDLE));
    scan_en = 1'b0;
    tick(2);

    // com_en dropped in WAIT during attempt 2: idle next cycle; after re-enable, full retry budget.
    fsm_req = 1'b1;
    c = cyc;
    q_tx.push_back('{cmd: OWT_CMD_WDG, addr: 7'h00, data: 8'h00, cyc: c + 1});
    q_tx.push_back('{cmd: OWT_CMD_WDG, addr: 7'h00, data: 8'h00, cyc: c + 4});
    tick(2);
    rx_drive(1'b0, 8'h00);
    tick(1);
    rx_off();
    tick(3);
    chk("wait_before_drop", 32'(cur_st), 32'(ARB_WAIT));
    com_en = 1'b0;
    tick(1);
    chk("idle_after_com_off", 32'(cur_st), 32'(ARB_IDLE));
    chk("tx_vld_com_off", 32'(owt.tx_vld), 32'd0);
    tick(3);
    com_en = 1'b1;
    q_tx.push_back('{cmd: OWT_CMD_WDG, addr: 7'h00, data: 8'h00, cyc: c + 11});
    q_tx.push_back('{cmd: OWT_CMD_WDG, addr: 7'h00, data: 8'h00, cyc: c + 21});
    q_tx.push_back('{cmd: OWT_CMD_WDG, addr: 7'h00, data: 8'h00, cyc: c + 31});
    q_cerr.push_back(c + 41);
    q_ack.push_back('{who: W_WDG, err: 1'b1, data: 8'hC3, cyc: c + 42});
    tick(32);
    drop(W_WDG);
    tick(3);

    // Async reset while in ARB_ISSUE clears outputs without waiting for a clock.
    owt.tx_rdy = 1'b0; rd_addr = 7'h22; rd_req = 1'b1;
    tick(1);
    chk("issue_before_rst", 32'(owt.tx_vld), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_tx_vld", 32'(owt.tx_vld), 32'd0);
    chk("async_rst_state", 32'(cur_st), 32'(ARB_IDLE));
    chk("async_rst_rsp_data", 32'(rsp_data), 32'd0);
    rd_req = 1'b0;
    tick(2);
    rst_n = 1'b1;
    owt.tx_rdy = 1'b1;
    tick(3);

    chk("q_tx_drained", q_tx.size(), 0);
    chk("q_ack_drained", q_ack.size(), 0);
    chk("q_cerr_drained", q_cerr.size(), 0);
    chk("q_miss_drained", q_miss.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
